// File: rtl/wb_arbiter3_if.sv
// wb_arbiter3_if
// Groups the three CPU-side master ports and the shared system-bus port of
// wb_arbiter3 into one bundle. Signal names keep the arbiter's i_/o_ view.
//
// Signals (N = 0,1,2):
//   i_mN_cyc / i_mN_stb[3:0] / i_mN_we / i_mN_addr[31:0] / i_mN_dat[31:0]
//       request from master N (stb bit 3 = data bits 31:24)
//   o_mN_dat[31:0] / o_mN_ack / o_mN_err
//       response to master N
//   o_wb_cyc / o_wb_stb[3:0] / o_wb_we / o_wb_addr[31:0] / o_wb_dat[31:0]
//       request to the system bus
//   i_wb_dat[31:0] / i_wb_ack / i_wb_err
//       response from the system bus
//
// Modports:
//   slave  - the arbiter's view (it serves the three masters)
//   master - the surrounding CPU units and bus slave driving the arbiter
interface wb_arbiter3_if;

  logic        i_m0_cyc;
  logic [3:0]  i_m0_stb;
  logic        i_m0_we;
  logic [31:0] i_m0_addr;
  logic [31:0] i_m0_dat;
  logic [31:0] o_m0_dat;
  logic        o_m0_ack;
  logic        o_m0_err;

  logic        i_m1_cyc;
  logic [3:0]  i_m1_stb;
  logic        i_m1_we;
  logic [31:0] i_m1_addr;
  logic [31:0] i_m1_dat;
  logic [31:0] o_m1_dat;
  logic        o_m1_ack;
  logic        o_m1_err;

  logic        i_m2_cyc;
  logic [3:0]  i_m2_stb;
  logic        i_m2_we;
  logic [31:0] i_m2_addr;
  logic [31:0] i_m2_dat;
  logic [31:0] o_m2_dat;
  logic        o_m2_ack;
  logic        o_m2_err;

  logic        o_wb_cyc;
  logic [3:0]  o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_addr;
  logic [31:0] o_wb_dat;
  logic [31:0] i_wb_dat;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport slave (
    input  i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_dat,
    output o_m0_dat, o_m0_ack, o_m0_err,
    input  i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_dat,
    output o_m1_dat, o_m1_ack, o_m1_err,
    input  i_m2_cyc, i_m2_stb, i_m2_we, i_m2_addr, i_m2_dat,
    output o_m2_dat, o_m2_ack, o_m2_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat,
    input  i_wb_dat, i_wb_ack, i_wb_err
  );

  modport master (
    output i_m0_cyc, i_m0_stb, i_m0_we, i_m0_addr, i_m0_dat,
    input  o_m0_dat, o_m0_ack, o_m0_err,
    output i_m1_cyc, i_m1_stb, i_m1_we, i_m1_addr, i_m1_dat,
    input  o_m1_dat, o_m1_ack, o_m1_err,
    output i_m2_cyc, i_m2_stb, i_m2_we, i_m2_addr, i_m2_dat,
    input  o_m2_dat, o_m2_ack, o_m2_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat,
    output i_wb_dat, i_wb_ack, i_wb_err
  );

endinterface

// File: rtl/wb_arbiter3.sv
// wb_arbiter3
// Shares one Wishbone port between instruction fetch (master 0), the load
// unit (master 1) and the store unit (master 2). Round-robin arbitration,
// grant locked for one transaction (until ack, err, master release or
// watchdog abort). A watchdog aborts accesses that see no ack/err within
// TIMEOUT busy cycles and reports an error to the requesting master.
//
// Parameters:
//   TIMEOUT  max busy cycles without ack/err before abort (2..65535)
// Ports:
//   i_clk      clock, rising edge
//   i_reset    synchronous, active-high reset
//   bus        wb_arbiter3_if.slave: master requests/responses + system bus
//   o_grant    granted master index, 2'd3 while idle
//   o_timeout  sticky: a watchdog abort has occurred
module wb_arbiter3 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_reset,
  wb_arbiter3_if.slave bus,
  output logic [1:0]   o_grant,
  output logic         o_timeout
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  localparam logic [15:0] LP_LIMIT = 16'(TIMEOUT - 1);
  localparam logic [1:0]  LP_NONE  = 2'd3;

  state_t      r_state;
  logic [1:0]  r_grant;
  logic [1:0]  r_last;
  logic [15:0] r_cnt;
  logic        r_timeout;

  logic        w_cyc [3];
  logic        w_req_any;
  logic [1:0]  w_pick;

  logic        w_gcyc;
  logic [3:0]  w_gstb;
  logic        w_gwe;
  logic [31:0] w_gaddr;
  logic [31:0] w_gdat;

  logic        w_busy;
  logic        w_live;
  logic        w_ack;
  logic        w_err;
  logic        w_to;

  assign w_cyc[0] = bus.i_m0_cyc;
  assign w_cyc[1] = bus.i_m1_cyc;
  assign w_cyc[2] = bus.i_m2_cyc;

  function automatic logic [1:0] rr_index(input logic [1:0] last,
                                          input int unsigned k);
    int unsigned s;
    s = (int'(last) + k) % 3;
    return 2'(s);
  endfunction

  // Scan last+3 down to last+1 so the lowest offset (highest priority)
  // requester is the one left in w_pick.
  always_comb begin
    w_req_any = 1'b0;
    w_pick    = r_last;
    for (int unsigned k = 3; k >= 1; k--) begin
      if (w_cyc[rr_index(r_last, k)]) begin
        w_req_any = 1'b1;
        w_pick    = rr_index(r_last, k);
      end
    end
  end

  always_comb begin
    w_gcyc  = 1'b0;
    w_gstb  = '0;
    w_gwe   = 1'b0;
    w_gaddr = '0;
    w_gdat  = '0;
    case (r_grant)
      2'd0: begin
        w_gcyc  = bus.i_m0_cyc;
        w_gstb  = bus.i_m0_stb;
        w_gwe   = bus.i_m0_we;
        w_gaddr = bus.i_m0_addr;
        w_gdat  = bus.i_m0_dat;
      end
      2'd1: begin
        w_gcyc  = bus.i_m1_cyc;
        w_gstb  = bus.i_m1_stb;
        w_gwe   = bus.i_m1_we;
        w_gaddr = bus.i_m1_addr;
        w_gdat  = bus.i_m1_dat;
      end
      2'd2: begin
        w_gcyc  = bus.i_m2_cyc;
        w_gstb  = bus.i_m2_stb;
        w_gwe   = bus.i_m2_we;
        w_gaddr = bus.i_m2_addr;
        w_gdat  = bus.i_m2_dat;
      end
      default: begin
        w_gcyc  = 1'b0;
      end
    endcase
  end

  // A master that has dropped cyc abandons the transaction, so bus
  // responses are only honoured while the granted master still holds cyc.
  // Priority within one cycle: ack > err > watchdog.
  assign w_busy = (r_state == S_BUSY);
  assign w_live = w_busy & w_gcyc;
  assign w_ack  = w_live & bus.i_wb_ack;
  assign w_err  = w_live & ~bus.i_wb_ack & bus.i_wb_err;
  assign w_to   = w_live & ~bus.i_wb_ack & ~bus.i_wb_err & (r_cnt == LP_LIMIT);

  assign bus.o_wb_cyc  = w_live & ~w_to;
  assign bus.o_wb_stb  = (w_busy & ~w_to) ? w_gstb : '0;
  assign bus.o_wb_we   = w_busy & w_gwe;
  assign bus.o_wb_addr = w_busy ? w_gaddr : '0;
  assign bus.o_wb_dat  = w_busy ? w_gdat  : '0;

  assign bus.o_m0_dat = bus.i_wb_dat;
  assign bus.o_m1_dat = bus.i_wb_dat;
  assign bus.o_m2_dat = bus.i_wb_dat;

  assign bus.o_m0_ack = w_ack & (r_grant == 2'd0);
  assign bus.o_m1_ack = w_ack & (r_grant == 2'd1);
  assign bus.o_m2_ack = w_ack & (r_grant == 2'd2);

  assign bus.o_m0_err = (w_err | w_to) & (r_grant == 2'd0);
  assign bus.o_m1_err = (w_err | w_to) & (r_grant == 2'd1);
  assign bus.o_m2_err = (w_err | w_to) & (r_grant == 2'd2);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_grant   <= LP_NONE;
      r_last    <= 2'd2;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_state <= S_BUSY;
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          if (!w_gcyc || w_ack || w_err || w_to) begin
            r_state <= S_IDLE;
            r_grant <= LP_NONE;
            if (w_to) begin
              r_timeout <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= LP_NONE;
        end
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_timeout = r_timeout;

endmodule

// File: tb/tb_wb_arbiter3.sv
module tb_wb_arbiter3;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       tout;

  wb_arbiter3_if bus ();

  wb_arbiter3 #(.TIMEOUT(TO)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .bus       (bus),
    .o_grant   (grant),
    .o_timeout (tout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: transaction-level view of the arbiter.
  bit m_valid = 0;
  int m_busy  = 0;
  int m_grant = 3;
  int m_last  = 2;
  int m_cnt   = 0;
  int m_to    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_cyc(input int n);
    case (n)
      0: return bus.i_m0_cyc;
      1: return bus.i_m1_cyc;
      default: return bus.i_m2_cyc;
    endcase
  endfunction
  function automatic logic [3:0] m_stb(input int n);
    case (n)
      0: return bus.i_m0_stb;
      1: return bus.i_m1_stb;
      default: return bus.i_m2_stb;
    endcase
  endfunction
  function automatic logic m_we(input int n);
    case (n)
      0: return bus.i_m0_we;
      1: return bus.i_m1_we;
      default: return bus.i_m2_we;
    endcase
  endfunction
  function automatic logic [31:0] m_addr(input int n);
    case (n)
      0: return bus.i_m0_addr;
      1: return bus.i_m1_addr;
      default: return bus.i_m2_addr;
    endcase
  endfunction
  function automatic logic [31:0] m_dat(input int n);
    case (n)
      0: return bus.i_m0_dat;
      1: return bus.i_m1_dat;
      default: return bus.i_m2_dat;
    endcase
  endfunction

  task automatic set_m(input int n, input logic c, input logic [3:0] s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    case (n)
      0: begin bus.i_m0_cyc = c; bus.i_m0_stb = s; bus.i_m0_we = w; bus.i_m0_addr = a; bus.i_m0_dat = d; end
      1: begin bus.i_m1_cyc = c; bus.i_m1_stb = s; bus.i_m1_we = w; bus.i_m1_addr = a; bus.i_m1_dat = d; end
      default: begin bus.i_m2_cyc = c; bus.i_m2_stb = s; bus.i_m2_we = w; bus.i_m2_addr = a; bus.i_m2_dat = d; end
    endcase
  endtask

  // Outcome of the current busy cycle: 0 continue, 1 ack, 2 err, 3 timeout, 4 abandoned
  function automatic int outcome();
    if (m_busy == 0) return 0;
    if (!m_cyc(m_grant)) return 4;
    if (bus.i_wb_ack) return 1;
    if (bus.i_wb_err) return 2;
    if (m_cnt == TO - 1) return 3;
    return 0;
  endfunction

  task automatic compare_model();
    int oc;
    bit live;
    logic [2:0] eack, eerr;
    oc   = outcome();
    live = (m_busy != 0) && m_cyc(m_grant);
    eack = '0;
    eerr = '0;
    if (oc == 1) eack[m_grant] = 1'b1;
    if (oc == 2 || oc == 3) eerr[m_grant] = 1'b1;
    chk("grant",   32'(grant), 32'(m_grant));
    chk("timeout", 32'(tout),  32'(m_to));
    chk("wb_cyc",  32'(bus.o_wb_cyc), 32'(live && oc != 3));
    chk("wb_stb",  32'(bus.o_wb_stb), (m_busy != 0 && oc != 3) ? 32'(m_stb(m_grant)) : 32'd0);
    chk("wb_we",   32'(bus.o_wb_we),  (m_busy != 0) ? 32'(m_we(m_grant)) : 32'd0);
    chk("wb_addr", bus.o_wb_addr,     (m_busy != 0) ? m_addr(m_grant) : 32'd0);
    chk("wb_dat",  bus.o_wb_dat,      (m_busy != 0) ? m_dat(m_grant) : 32'd0);
    chk("acks",    32'({bus.o_m2_ack, bus.o_m1_ack, bus.o_m0_ack}), 32'(eack));
    chk("errs",    32'({bus.o_m2_err, bus.o_m1_err, bus.o_m0_err}), 32'(eerr));
    chk("m0_dat",  bus.o_m0_dat, bus.i_wb_dat);
    chk("m1_dat",  bus.o_m1_dat, bus.i_wb_dat);
    chk("m2_dat",  bus.o_m2_dat, bus.i_wb_dat);
  endtask

  task automatic update_model();
    int oc;
    if (rst) begin
      m_valid = 1;
      m_busy  = 0;
      m_grant = 3;
      m_last  = 2;
      m_cnt   = 0;
      m_to    = 0;
    end else if (m_busy == 0) begin
      for (int k = 1; k <= 3; k++) begin
        if (m_busy == 0 && m_cyc((m_last + k) % 3)) begin
          m_busy  = 1;
          m_grant = (m_last + k) % 3;
          m_last  = m_grant;
          m_cnt   = 0;
        end
      end
    end else begin
      oc = outcome();
      if (oc == 0) begin
        m_cnt++;
      end else begin
        m_busy  = 0;
        m_grant = 3;
        if (oc == 3) m_to = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (m_valid) compare_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle_all();
    for (int n = 0; n < 3; n++) set_m(n, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
    bus.i_wb_ack = 1'b0;
    bus.i_wb_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  int exp_g [12] = '{0, 0, 3, 1, 1, 3, 2, 2, 3, 0, 0, 3};

  initial begin
    rst = 1'b1;
    idle_all();
    bus.i_wb_dat = 32'h0;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_cyc",   32'(bus.o_wb_cyc), 32'd0);
    chk("rst_tout",  32'(tout), 32'd0);

    // m1 read at 0x100, acked 3 cycles after cyc rises
    set_m(1, 1'b1, 4'b1000, 1'b0, 32'h100, 32'h0);
    cycle();
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_addr",  bus.o_wb_addr, 32'h100);
    chk("t1_cyc",   32'(bus.o_wb_cyc), 32'd1);
    cycle();
    cycle();
    bus.i_wb_ack = 1'b1;
    bus.i_wb_dat = 32'hAABBCCDD;
    #1;
    chk("t1_ack",     32'(bus.o_m1_ack), 32'd1);
    chk("t1_dat",     bus.o_m1_dat, 32'hAABBCCDD);
    chk("t1_oth_ack", 32'({bus.o_m2_ack, bus.o_m0_ack}), 32'd0);
    cycle();
    idle_all();
    #1;
    chk("t1_ack_end", 32'(bus.o_m1_ack), 32'd0);
    chk("t1_idle",    32'(grant), 32'd3);

    // all three request and hold; round-robin with one idle slot between
    do_reset();
    for (int n = 0; n < 3; n++) set_m(n, 1'b1, 4'hF, 1'b0, 32'(n * 16), 32'h0);
    for (int i = 0; i < 12; i++) begin
      bus.i_wb_ack = (m_busy != 0 && m_cnt == 1);
      cycle();
      chk("rr_seq", 32'(grant), 32'(exp_g[i]));
    end
    idle_all();
    cycle();
    cycle();

    // bus error for m1, then a stray ack while idle
    do_reset();
    set_m(1, 1'b1, 4'b0011, 1'b0, 32'h44, 32'h0);
    cycle();
    bus.i_wb_err = 1'b1;
    #1;
    chk("t4_err",    32'(bus.o_m1_err), 32'd1);
    chk("t4_noack",  32'(bus.o_m1_ack), 32'd0);
    cycle();
    idle_all();
    #1;
    chk("t4_err_end", 32'(bus.o_m1_err), 32'd0);
    chk("t4_tout",    32'(tout), 32'd0);
    bus.i_wb_ack = 1'b1;
    #1;
    chk("t4_idle_ack", 32'({bus.o_m2_ack, bus.o_m1_ack, bus.o_m0_ack}), 32'd0);
    cycle();
    idle_all();

    // m2 write to a slave that never answers -> watchdog
    set_m(2, 1'b1, 4'b1111, 1'b1, 32'h20, 32'h12345678);
    cycle();
    chk("t3_grant", 32'(grant), 32'd2);
    for (int i = 0; i < TO - 1; i++) begin
      chk("t3_no_err", 32'(bus.o_m2_err), 32'd0);
      chk("t3_cyc",    32'(bus.o_wb_cyc), 32'd1);
      cycle();
    end
    chk("t3_err",   32'(bus.o_m2_err), 32'd1);
    chk("t3_cyc0",  32'(bus.o_wb_cyc), 32'd0);
    chk("t3_stb0",  32'(bus.o_wb_stb), 32'd0);
    cycle();
    chk("t3_tout",  32'(tout), 32'd1);
    chk("t3_idle",  32'(grant), 32'd3);
    cycle();
    chk("t3_regrant", 32'(grant), 32'd2);
    idle_all();
    cycle();
    chk("t3_abandon", 32'(grant), 32'd3);

    // reset in the middle of an m0 transaction
    do_reset();
    set_m(0, 1'b1, 4'hF, 1'b0, 32'h80, 32'h0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.i_wb_ack = 1'b1;
    #1;
    chk("t5_noack", 32'(bus.o_m0_ack), 32'd0);
    chk("t5_grant", 32'(grant), 32'd3);
    chk("t5_cyc",   32'(bus.o_wb_cyc), 32'd0);
    bus.i_wb_ack = 1'b0;
    set_m(1, 1'b1, 4'hF, 1'b0, 32'h90, 32'h0);
    cycle();
    chk("t5_first", 32'(grant), 32'd0);
    idle_all();
    cycle();
    cycle();

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int n = 0; n < 3; n++) begin
        logic c;
        c = m_cyc(n) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
        set_m(n, c, 4'($urandom), 1'($urandom), $urandom, $urandom);
      end
      bus.i_wb_ack = ($urandom_range(0, 4) == 0);
      bus.i_wb_err = ($urandom_range(0, 11) == 0);
      bus.i_wb_dat = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter3.md
# wb_arbiter3

Three-master Wishbone arbiter that shares the CPU's single data/instruction bus port between instruction fetch (master 0), the load unit (master 1) and the store unit (master 2). Arbitration is round-robin and locked for one transaction: grant is held until ack, err, master release or watchdog timeout. A per-transaction watchdog terminates hung accesses with an error to the requesting master. The arbiter sits between the CPU access units and the system bus; byte lanes are carried on the 4-bit strobe, bit 3 = bits 31:24.

## Interface
- TIMEOUT, 255: max BUSY cycles without ack/err before abort; legal range 2..65535; counter is 16 bits.
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_mN_cyc  in  1  request/cycle valid from master N (N = 0,1,2).
- i_mN_stb  in  4  byte-lane strobes from master N.
- i_mN_we  in  1  write enable from master N.
- i_mN_addr  in  32  word address from master N.
- i_mN_dat  in  32  write data from master N.
- o_mN_dat  out  32  read data to master N; i_wb_dat broadcast to all masters.
- o_mN_ack  out  1  ack to master N; only the granted master.
- o_mN_err  out  1  error to master N; bus err or timeout, granted master only.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  4  bus byte strobes.
- o_wb_we  out  1  bus write enable.
- o_wb_addr  out  32  bus address.
- o_wb_dat  out  32  bus write data.
- i_wb_dat  in  32  bus read data.
- i_wb_ack  in  1  bus acknowledge.
- i_wb_err  in  1  bus error.
- o_grant  out  2  granted master index; 2'd3 when IDLE.
- o_timeout  out  1  sticky flag: a watchdog abort has occurred.

## Operation
- States: IDLE, BUSY. Registers: state, grant index, last-granted index `last`, 16-bit counter `cnt`, `o_timeout`.
- IDLE: if any i_mN_cyc is high, grant the first requester in order last+1, last+2, last (mod 3). Next state BUSY, cnt <= 0, last <= granted index.
- BUSY: bus outputs mux from granted master. o_wb_cyc = granted i_mN_cyc and not aborting.
- In BUSY, i_wb_ack routes to o_mN_ack and i_wb_err to o_mN_err of the granted master, in the same cycle (combinational). Either ends the transaction: next state IDLE.
- In BUSY, if the granted master drops cyc, the transaction is abandoned: next state IDLE, no ack/err delivered.
- Watchdog: cnt increments each BUSY cycle without ack/err. If cnt == TIMEOUT-1 and no ack/err: o_mN_err pulses that cycle, o_wb_cyc and o_wb_stb are forced to 0 that cycle, o_timeout <= 1, next state IDLE.
- Priority in the same cycle: ack > err > timeout. An ack arriving in the timeout cycle is a normal ack, with no error and no flag.
- IDLE outputs: o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_dat are all 0. i_wb_ack and i_wb_err are ignored. All o_mN_ack and o_mN_err are 0.
- Reset: state IDLE, last <= 2 (master 0 has first priority), cnt 0, o_timeout 0, o_grant 3. All outputs take their IDLE values from the next cycle.
- Reset during BUSY: the transaction is dropped and no ack/err is forwarded after the reset edge.

## Timing
- Request seen in IDLE at edge N: o_grant and o_wb_cyc are valid after edge N, so the bus cycle starts one cycle after the request.
- Ack in cycle K: o_mN_ack is asserted in cycle K and the state is IDLE after edge K.
- At least one IDLE cycle separates back-to-back transactions. This is the rearbitration slot: a master holding cyc high competes again.
- With all three masters requesting continuously, grants rotate 0,1,2,0,...
- Timeout: the error fires in BUSY cycle TIMEOUT-1, counted from 0. The bus is then released for at least one cycle.
- Strobes come straight through the mux. A master's late stb (registered one cycle after its cyc) is passed through unchanged.

## Test plan
- Reset, then m1 requests a read at 0x100 with stb 4'b1000; slave acks 3 cycles after o_wb_cyc rises with 0xAABBCCDD -> o_grant=1, o_wb_addr=0x100, o_m1_ack a single pulse with o_m1_dat=0xAABBCCDD, o_m0_ack and o_m2_ack stay 0, then IDLE.
- m0, m1 and m2 request simultaneously and hold, slave acks each after 1 cycle -> grant sequence 0,1,2,0 with one IDLE cycle between grants.
- m2 writes 0x12345678 to 0x20 with stb 4'b1111; the slave never responds; TIMEOUT=8 -> o_m2_err pulses in the 8th BUSY cycle, o_wb_cyc is 0 in that cycle, o_timeout=1, next grant is possible.
- Slave asserts i_wb_err for m1 -> o_m1_err is 1 for one cycle, o_timeout stays 0; an i_wb_ack while IDLE produces no master ack.
- m0 granted, then i_reset is asserted mid-transaction and an ack arrives after reset -> no o_m0_ack, o_grant=3, o_wb_cyc=0. After reset, m1 and m0 both request -> m0 is granted first.
